// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit/receive stages.
// Build option: UART_TX_PARITY_EN adds the PARITY state to the transmit FSM.
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_TX_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } uart_tx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-time counter: pulses bit_done in the last clk cycle of every serial bit.
// Shared between the transmit and receive stages.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count_q, count_d;

  assign bit_done = (count_q == LAST_COUNT);

  // Count up through one bit time, restarting at each bit boundary or when held clear
  always_comb begin
    count_d = count_q + CW'(1);
    if (clear || bit_done) begin
      count_d = '0;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// Byte-wide UART transmitter: 8 data bits LSB first, 1 or 2 stop bits.
// Build option: define UART_TX_PARITY_EN to insert a parity bit (sense set by PARITY_ODD).
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 2,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy
);

  if (CLKS_PER_BIT < 1 || (STOP_BITS != 1 && STOP_BITS != 2) ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : gBadParams
    $error("uart_tx_frame: illegal parameter value");
  end

  uart_tx_state_t            state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]                bitIdx_q, bitIdx_d;
  logic                      stopIdx_q, stopIdx_d;
  logic                      tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic                      parity_q, parity_d;
`endif

  logic bitDone;
  logic lastStop;
  logic accept;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) uBitTimer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_q == TX_IDLE),
    .bit_done(bitDone)
  );

  // The final cycle of the last stop bit can already take the next byte
  assign lastStop = (state_q == TX_STOP) && bitDone && (stopIdx_q == 1'(STOP_BITS - 1));
  assign tx_ready = (state_q == TX_IDLE) || lastStop;
  assign accept   = tx_valid && tx_ready;
  assign tx_busy  = (state_q != TX_IDLE);
  assign tx       = tx_q;

  // Next-state logic for the frame FSM and its datapath registers
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bitIdx_d  = bitIdx_q;
    stopIdx_d = stopIdx_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      TX_IDLE: begin
        if (accept) begin
          state_d = TX_START;
          shift_d = tx_data;
`ifdef UART_TX_PARITY_EN
          parity_d = 1'b0;
`endif
        end
      end
      TX_START: begin
        if (bitDone) begin
          state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (bitDone) begin
`ifdef UART_TX_PARITY_EN
          parity_d = parity_q ^ shift_q[0];
`endif
          shift_d = shift_q >> 1;
          if (bitIdx_q == 3'(UART_DATA_BITS - 1)) begin
            bitIdx_d = 3'd0;
`ifdef UART_TX_PARITY_EN
            state_d  = TX_PARITY;
`else
            state_d  = TX_STOP;
`endif
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      TX_PARITY: begin
        if (bitDone) begin
          state_d = TX_STOP;
        end
      end
`endif
      TX_STOP: begin
        if (lastStop) begin
          stopIdx_d = 1'b0;
          if (accept) begin
            state_d = TX_START;
            shift_d = tx_data;
`ifdef UART_TX_PARITY_EN
            parity_d = 1'b0;
`endif
          end else begin
            state_d = TX_IDLE;
          end
        end else if (bitDone) begin
          stopIdx_d = stopIdx_q + 1'b1;
        end
      end
      default: begin
        state_d = TX_IDLE;
      end
    endcase
  end

  // Line level for the upcoming cycle, derived from next state so tx is a clean flop
  always_comb begin
    tx_d = UART_IDLE_LEVEL;
    case (state_d)
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      TX_PARITY: tx_d = parity_d ^ 1'(PARITY_ODD);
`endif
      default:   tx_d = UART_IDLE_LEVEL;
    endcase
  end

  // State and datapath registers; reset drops any partial frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= TX_IDLE;
      shift_q   <= '0;
      bitIdx_q  <= '0;
      stopIdx_q <= 1'b0;
      tx_q      <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bitIdx_q  <= bitIdx_d;
      stopIdx_q <= stopIdx_d;
      tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Testbench for uart_tx_frame: cycle-level frame checks plus a line-decoding scoreboard.
// Honours UART_TX_PARITY_EN the same way as the design.
module tb_uart_tx_frame;

  localparam int CPB  = 2;
  localparam int STOP = 1;
  localparam int PODD = 0;
`ifdef UART_TX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  localparam int FRAME_BITS = 1 + 8 + PBITS + STOP;
  localparam int FRAME      = FRAME_BITS * CPB;

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;

  int totalChecks = 0;
  int badChecks   = 0;
  int acceptCount = 0;
  bit resetSeen   = 1'b0;
  logic [7:0] expQ[$];

  uart_tx_frame #(
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (STOP),
    .PARITY_ODD  (PODD)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx      (tx),
    .tx_busy (tx_busy)
  );

  initial clk = 1'b0;
  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  // Count handshakes as the design sees them on the rising edge
  always @(posedge clk) begin
    if (rst_n && tx_valid && tx_ready) acceptCount++;
  end

  // Remember that a reset happened so a truncated frame is not scored
  always @(negedge rst_n) resetSeen = 1'b1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Expected line level during bit slot b of a frame carrying byte d
  function automatic logic expBit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (PBITS == 1 && b == 9) return (^d) ^ 1'(PODD);
    return 1'b1;
  endfunction

  task automatic applyStimulus(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    checkOutput("readyBeforeAccept", {31'd0, tx_ready}, 32'd1);
    expQ.push_back(d);
    @(posedge clk);
  endtask

  // Check nCyc cycles of the frame for d; optionally present nextD for a back-to-back accept
  task automatic checkFrame(input logic [7:0] d, input int nCyc, input bit chainNext,
                            input logic [7:0] nextD, input string tag);
    for (int c = 0; c < nCyc; c++) begin
      @(negedge clk);
      if (c == 0) begin
        if (chainNext) begin
          tx_data = nextD;
        end else begin
          tx_valid = 1'b0;
          tx_data  = ~d;
        end
      end
      checkOutput($sformatf("%s.cyc%0d", tag, c), {29'd0, tx, tx_busy, tx_ready},
                  {29'd0, expBit(d, c / CPB), 1'b1, (c == FRAME - 1)});
      if (chainNext && c == FRAME - 1) expQ.push_back(nextD);
    end
  endtask

  task automatic checkIdle(input int nCyc, input string tag);
    for (int c = 0; c < nCyc; c++) begin
      @(negedge clk);
      checkOutput($sformatf("%s.cyc%0d", tag, c), {29'd0, tx, tx_ready, tx_busy}, 32'b110);
    end
  endtask

  // Line receiver model: decode each frame from tx and score it against the queue
  initial begin
    logic [15:0] frameBits;
    logic [7:0]  got;
    logic [7:0]  want;
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        resetSeen = 1'b0;
        frameBits = '0;
        for (int b = 1; b < FRAME_BITS; b++) begin
          repeat (CPB) @(negedge clk);
          frameBits[b] = tx;
        end
        repeat (CPB - 1) @(negedge clk);
        if (!resetSeen) begin
          got = frameBits[8:1];
          if (expQ.size() == 0) begin
            checkOutput("rxUnexpectedFrame", {24'd0, got}, 32'hFFFF_FFFF);
          end else begin
            want = expQ.pop_front();
            checkOutput("rxByte", {24'd0, got}, {24'd0, want});
            if (PBITS == 1) begin
              checkOutput("rxParity", {31'd0, frameBits[9]}, {31'd0, (^want) ^ 1'(PODD)});
            end
            for (int s = 0; s < STOP; s++) begin
              checkOutput("rxStop", {31'd0, frameBits[9 + PBITS + s]}, 32'd1);
            end
          end
        end
      end
    end
  end

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence
  initial begin
    int acceptsBefore;
    rst_n    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    #1 rst_n = 1'b0;
    #1 checkOutput("resetState", {29'd0, tx, tx_ready, tx_busy}, 32'b110);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    checkIdle(16, "idle");

    applyStimulus(8'hA5);
    checkFrame(8'hA5, FRAME, 1'b0, 8'h00, "frameA5");
    checkIdle(3, "gapA5");

    acceptsBefore = acceptCount;
    applyStimulus(8'h00);
    checkFrame(8'h00, FRAME, 1'b1, 8'hFF, "frame00");
    checkFrame(8'hFF, FRAME, 1'b0, 8'h00, "frameFF");
    checkIdle(4, "gapFF");
    checkOutput("acceptsBackToBack", acceptCount - acceptsBefore, 32'd2);

    applyStimulus(8'h3C);
    checkFrame(8'h3C, 6, 1'b0, 8'h00, "frame3C");
    #2 rst_n = 1'b0;
    #1 checkOutput("asyncResetMidFrame", {29'd0, tx, tx_ready, tx_busy}, 32'b110);
    void'(expQ.pop_back());
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checkIdle(FRAME + 2, "afterReset");
    applyStimulus(8'h81);
    checkFrame(8'h81, FRAME, 1'b0, 8'h00, "frame81");
    checkIdle(3, "gap81");

    applyStimulus(8'h55);
    checkFrame(8'h55, FRAME, 1'b1, 8'hAA, "frame55");
    checkFrame(8'hAA, FRAME, 1'b1, 8'h01, "frameAA");
    checkFrame(8'h01, FRAME, 1'b0, 8'h00, "frame01");
    checkIdle(3, "gap01");

    applyStimulus(8'h07);
    checkFrame(8'h07, FRAME, 1'b0, 8'h00, "frame07");
    checkIdle(4, "gap07");

    for (int i = 0; i < 20 && expQ.size() != 0; i++) @(negedge clk);
    checkOutput("scoreboardDrained", expQ.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
